// File: rtl/execute_stage.sv
// execute_stage: cqu_mips EX stage with ALU, HI/LO, optional iterative divider and EX/MEM register
// Ports: clk, rst (async, active-high); decode side in_valid, alu_op, src_a, src_b,
//   store_data_in, write_reg_in, reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
//   stall_in from downstream; busy to upstream; registered EX/MEM outputs alu_result,
//   mem_addr, write_data, write_reg_out, reg_write_out, mem_read_out, mem_write_out,
//   mem_to_reg_out, overflow_out.
// Build option: define EXEC_DIV_EN to build the 32-cycle restoring divider.
module execute_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  write_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        stall_in,
  output logic        busy,
  output logic [31:0] alu_result,
  output logic [31:0] mem_addr,
  output logic [31:0] write_data,
  output logic [4:0]  write_reg_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        mem_to_reg_out,
  output logic        overflow_out
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd2, OP_MULT = 5'd14, OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16, OP_DIVU = 5'd17, OP_MFHI = 5'd18, OP_MFLO = 5'd19;
  localparam logic [4:0] OP_MTHI = 5'd20, OP_MTLO = 5'd21;
  logic [31:0] hi, lo, sum, diff, result, div_hi, div_lo;
  logic [63:0] prod_s, prod_u;
  logic ovf, hilo_op, accept, div_wr;
  assign sum = src_a + src_b;
  assign diff = src_a - src_b;
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'b0, src_a} * {32'b0, src_b};
  assign ovf = (alu_op == OP_ADD && src_a[31] == src_b[31] && sum[31] != src_a[31]) ||
               (alu_op == OP_SUB && src_a[31] != src_b[31] && diff[31] != src_a[31]);
  assign hilo_op = alu_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
  assign accept = in_valid && !stall_in && !busy;
  always_comb begin
    result = '0;
    case (alu_op)
      5'd0, 5'd1: result = sum;
      5'd2, 5'd3: result = diff;
      5'd4:       result = src_a & src_b;
      5'd5:       result = src_a | src_b;
      5'd6:       result = src_a ^ src_b;
      5'd7:       result = ~(src_a | src_b);
      5'd8:       result = {31'b0, $signed(src_a) < $signed(src_b)};
      5'd9:       result = {31'b0, src_a < src_b};
      5'd10:      result = src_b << src_a[4:0];
      5'd11:      result = src_b >> src_a[4:0];
      5'd12:      result = $signed(src_b) >>> src_a[4:0];
      5'd13:      result = {src_b[15:0], 16'b0};
      OP_MFHI:    result = hi;
      OP_MFLO:    result = lo;
      default:    result = '0;
    endcase
  end
`ifdef EXEC_DIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] count;
  logic [31:0] q, d, r, a_keep;
  logic [32:0] r_sh;
  logic neg_q, neg_r, div_zero, div_op, sgn, start;
  assign div_op = alu_op == OP_DIV || alu_op == OP_DIVU;
  assign sgn = alu_op == OP_DIV;
  assign start = state == IDLE && in_valid && div_op;
  assign busy = start || state == RUN;
  assign r_sh = {r, q[31]};
  assign div_wr = state == DONE && !stall_in;
  // Divide-by-zero bypasses the sign fixup and reports the raw dividend in HI.
  assign div_lo = div_zero ? '1 : neg_q ? -q : q;
  assign div_hi = div_zero ? a_keep : neg_r ? -r : r;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == 5'(DIV_CYCLES - 1)) state_nx = DONE;
      DONE:    if (!stall_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0; q <= '0; d <= '0; r <= '0; a_keep <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; div_zero <= 1'b0;
    end else if (start) begin
      count <= '0;
      r <= '0;
      q <= (sgn && src_a[31]) ? -src_a : src_a;
      d <= (sgn && src_b[31]) ? -src_b : src_b;
      a_keep <= src_a;
      neg_q <= sgn && (src_a[31] ^ src_b[31]);
      neg_r <= sgn && src_a[31];
      div_zero <= src_b == '0;
    end else if (state == RUN) begin
      count <= count + 5'd1;
      r <= (r_sh >= {1'b0, d}) ? 32'(r_sh - {1'b0, d}) : r_sh[31:0];
      q <= {q[30:0], r_sh >= {1'b0, d}};
    end
`else
  assign busy = 1'b0;
  assign div_wr = 1'b0;
  assign div_hi = hi;
  assign div_lo = lo;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_wr) begin
      hi <= div_hi;
      lo <= div_lo;
    end else if (accept) begin
      if (alu_op == OP_MULT) {hi, lo} <= prod_s;
      else if (alu_op == OP_MULTU) {hi, lo} <= prod_u;
      else if (alu_op == OP_MTHI) hi <= src_a;
      else if (alu_op == OP_MTLO) lo <= src_a;
    end
  // Any non-stalled cycle without an accepted instruction loads a bubble.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_result <= '0; mem_addr <= '0; write_data <= '0; write_reg_out <= '0;
      reg_write_out <= 1'b0; mem_read_out <= 1'b0; mem_write_out <= 1'b0;
      mem_to_reg_out <= 1'b0; overflow_out <= 1'b0;
    end else if (!stall_in) begin
      alu_result <= accept ? result : '0;
      mem_addr <= accept ? sum : '0;
      write_data <= accept ? store_data_in : '0;
      write_reg_out <= accept ? write_reg_in : '0;
      reg_write_out <= accept && reg_write_in && !ovf && !hilo_op;
      mem_read_out <= accept && mem_read_in;
      mem_write_out <= accept && mem_write_in;
      mem_to_reg_out <= accept && mem_to_reg_in;
      overflow_out <= accept && ovf;
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  logic clk = 0, rst = 1, in_valid = 0, stall_in = 0;
  logic [4:0] alu_op = '0, write_reg_in = '0, write_reg_out;
  logic [31:0] src_a = '0, src_b = '0, store_data_in = '0;
  logic reg_write_in = 0, mem_read_in = 0, mem_write_in = 0, mem_to_reg_in = 0;
  logic busy, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out, overflow_out;
  logic [31:0] alu_result, mem_addr, write_data;
  int checks = 0, errors = 0;
  execute_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .store_data_in(store_data_in), .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .stall_in(stall_in), .busy(busy), .alu_result(alu_result), .mem_addr(mem_addr),
    .write_data(write_data), .write_reg_out(write_reg_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
    .overflow_out(overflow_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rw, input logic mr);
    in_valid = 1; alu_op = op; src_a = a; src_b = b; reg_write_in = rw;
    mem_read_in = mr; mem_to_reg_in = mr; mem_write_in = 0;
    store_data_in = 32'h5A5A_0000 ^ b; write_reg_in = 5'd7;
  endtask
  task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 1, 0);
    tick;
    check(tag, alu_result, exp);
  endtask
  task automatic read_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    drive(5'd18, 0, 0, 1, 0);
    tick;
    check({tag, "_hi"}, alu_result, hi_exp);
    drive(5'd19, 0, 0, 1, 0);
    tick;
    check({tag, "_lo"}, alu_result, lo_exp);
  endtask
  task automatic wait_div(output int n);
    n = 0;
    #1;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      if (n == 10) begin
        check("div_bubble_res", alu_result, 0);
        check("div_bubble_addr", mem_addr, 0);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) tick;
    check("rst_result", alu_result, 0);
    check("rst_busy", busy, 0);
    check("rst_regwr", reg_write_out, 0);
    rst = 0;
    tick;
    drive(5'd0, 32'h7FFF_FFFF, 1, 1, 0);
    tick;
    check("add_ovf_res", alu_result, 32'h8000_0000);
    check("add_ovf", overflow_out, 1);
    check("add_ovf_rw", reg_write_out, 0);
    drive(5'd1, 32'h7FFF_FFFF, 1, 1, 0);
    tick;
    check("addu_ovf", overflow_out, 0);
    check("addu_rw", reg_write_out, 1);
    check("addu_addr", mem_addr, 32'h8000_0000);
    check("addu_wdata", write_data, 32'h5A5A_0001);
    drive(5'd2, 32'h8000_0000, 1, 1, 0);
    tick;
    check("sub_ovf", overflow_out, 1);
    check("sub_res", alu_result, 32'h7FFF_FFFF);
    alu("subu", 5'd3, 1, 2, 32'hFFFF_FFFF);
    check("subu_ovf", overflow_out, 0);
    alu("and", 5'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu("or", 5'd5, 32'h0F0, 32'hF00, 32'hFF0);
    alu("xor", 5'd6, 32'hF0F0, 32'hFF00, 32'h0FF0);
    alu("nor", 5'd7, 0, 0, 32'hFFFF_FFFF);
    alu("slt", 5'd8, 32'hFFFF_FFFF, 1, 1);
    alu("sltu", 5'd9, 32'hFFFF_FFFF, 1, 0);
    alu("sll", 5'd10, 4, 1, 32'h10);
    alu("srl", 5'd11, 4, 32'h8000_0000, 32'h0800_0000);
    alu("sra", 5'd12, 4, 32'h8000_0000, 32'hF800_0000);
    alu("lui", 5'd13, 0, 32'h1234, 32'h1234_0000);
    alu("op25", 5'd25, 1, 2, 0);
    drive(5'd14, 32'hFFFF_FFFF, 2, 1, 0);
    tick;
    check("mult_rw", reg_write_out, 0);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    drive(5'd15, 32'hFFFF_FFFF, 2, 1, 0);
    tick;
    read_hilo("multu", 32'h1, 32'hFFFF_FFFE);
    drive(5'd1, 32'hF0, 32'h10, 1, 1);
    tick;
    check("lw_addr", mem_addr, 32'h100);
    check("lw_rd", mem_read_out, 1);
    stall_in = 1;
    drive(5'd1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stall_addr", mem_addr, 32'h100);
      check("stall_rd", mem_read_out, 1);
    end
    stall_in = 0;
    tick;
    check("unstall_addr", mem_addr, 0);
    in_valid = 0;
    tick;
    check("bubble_rw", reg_write_out, 0);
    drive(5'd20, 32'h11, 0, 1, 0);
    tick;
    drive(5'd21, 32'h22, 0, 1, 0);
    tick;
    check("mt_rw", reg_write_out, 0);
    read_hilo("mt", 32'h11, 32'h22);
`ifdef EXEC_DIV_EN
    drive(5'd16, 32'hFFFF_FFF9, 2, 1, 0);
    wait_div(n);
    check("div_busy_cycles", n, 33);
    tick;
    check("div_retire_addr", mem_addr, 32'hFFFF_FFFB);
    check("div_retire_rw", reg_write_out, 0);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive(5'd17, 5, 0, 1, 0);
    wait_div(n);
    check("divu0_busy_cycles", n, 33);
    stall_in = 1;
    repeat (2) tick;
    check("done_stall_busy", busy, 0);
    check("done_stall_addr", mem_addr, 0);
    stall_in = 0;
    tick;
    check("done_release_addr", mem_addr, 5);
    read_hilo("divu0", 32'h5, 32'hFFFF_FFFF);
    drive(5'd17, 100, 7, 1, 0);
    repeat (11) tick;
    check("mid_div_busy", busy, 1);
    in_valid = 0;
    rst = 1;
    #1;
    check("rst_div_busy", busy, 0);
    check("rst_div_addr", mem_addr, 0);
    tick;
    rst = 0;
    read_hilo("rst_div", 0, 0);
    drive(5'd17, 9, 3, 1, 0);
    wait_div(n);
    check("divu93_busy_cycles", n, 33);
    tick;
    read_hilo("divu93", 0, 3);
`else
    drive(5'd17, 5, 0, 1, 0);
    #1;
    check("nodiv_busy", busy, 0);
    tick;
    check("nodiv_addr", mem_addr, 5);
    check("nodiv_rw", reg_write_out, 0);
    read_hilo("nodiv", 32'h11, 32'h22);
    in_valid = 0;
    rst = 1;
    #1;
    check("rst2_addr", mem_addr, 0);
    tick;
    rst = 0;
    read_hilo("rst2", 0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
